// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fb_arbiter
//  Purpose  : Shares one single-port frame-buffer memory between VGA scanout
//             reads and a buffered pixel-writer client. Scanout owns the
//             memory whenever at_display_area is high; queued writes drain
//             only in blanking cycles. Returned pixels are realigned to the
//             memory read latency.
//  Ports    : vga_clock, reset_n        - pixel clock, async active-low reset
//             hcount, vcount,
//             at_display_area           - VGA timing generator inputs
//             wr_valid/wr_ready,
//             wr_addr/wr_data           - pixel-writer request channel
//             mem_addr/mem_we/
//             mem_wdata/mem_rdata       - single-port memory (addr MSB = bank)
//             pix_data/pix_valid        - latency-aligned scanout pixel
//             fifo_level, drop_count    - write queue occupancy, refusals
//             swap_req/swap_done        - bank swap (FB_DOUBLE_BUFFER_EN only)
//  Options  : `define FB_DOUBLE_BUFFER_EN for front/back bank double buffering;
//             otherwise the bank bit of mem_addr is constant 0.
//  Revision : 1.0  initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int RD_LAT     = 2
) (
    input  logic                            vga_clock,
    input  logic                            reset_n,
    input  logic [9:0]                      hcount,
    input  logic [9:0]                      vcount,
    input  logic                            at_display_area,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [DATA_W-1:0]               wr_data,
    output logic [ADDR_W:0]                 mem_addr,
    output logic                            mem_we,
    output logic [DATA_W-1:0]               mem_wdata,
    input  logic [DATA_W-1:0]               mem_rdata,
    output logic [DATA_W-1:0]               pix_data,
    output logic                            pix_valid,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
`ifdef FB_DOUBLE_BUFFER_EN
    input  logic                            swap_req,
    output logic                            swap_done,
`endif
    output logic [15:0]                     drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [9:0]       c_v_active = 10'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_full     = CNT_W'(FIFO_DEPTH);

    // Parameter sanity checks, evaluated at elaboration.
    generate
        if (H_ACTIVE * V_ACTIVE > (1 << ADDR_W)) begin : g_chk_geometry
            $error("vga_fb_arbiter: H_ACTIVE*V_ACTIVE exceeds 2**ADDR_W");
        end
        if ((FIFO_DEPTH < 2) || ((1 << PTR_W) != FIFO_DEPTH)) begin : g_chk_depth
            $error("vga_fb_arbiter: FIFO_DEPTH must be a power of 2 and >= 2");
        end
        if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_chk_lat
            $error("vga_fb_arbiter: RD_LAT must be 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DISPLAY = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    // Write FIFO
    logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_next;
    logic                r_not_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic [15:0]         r_drop_count;

    // Scanout
    logic [ADDR_W-1:0]   r_scan_addr;
    logic                r_frame_ok;
    logic [RD_LAT:0]     r_valid_sr;

    // Memory port
    logic [ADDR_W:0]     r_mem_addr;
    logic                r_mem_we;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [ADDR_W:0]     w_mem_addr_d;
    logic                w_mem_we_d;
    logic [DATA_W-1:0]   w_mem_wdata_d;

    logic                w_front_bank;
    logic                w_back_bank;

`ifdef FB_DOUBLE_BUFFER_EN
    logic                r_front_bank;
    logic                r_swap_pending;
    logic                w_do_swap;

    // hcount==0 at vcount==V_ACTIVE occurs on exactly one cycle per frame.
    assign w_do_swap    = r_swap_pending && (vcount == c_v_active) && (hcount == 10'd0);
    assign w_front_bank = r_front_bank;
    assign w_back_bank  = ~r_front_bank;
    assign swap_done    = w_do_swap;
`else
    // hcount only matters for the bank-swap boundary.
    logic                w_unused_hcount;
    assign w_unused_hcount = ^hcount;
    assign w_front_bank    = 1'b0;
    assign w_back_bank     = 1'b0;
`endif

    assign w_empty = (r_count == '0);

    // Ready is the registered not-full flag, widened by a same-cycle pop so a
    // full queue keeps accepting while it drains. The pop term depends only
    // on at_display_area and registered occupancy, never on wr_valid.
    assign wr_ready = r_not_full | w_pop;
    assign w_push   = wr_valid & wr_ready;
    assign w_drop   = wr_valid & ~wr_ready;

    always_comb begin
        w_count_next = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Arbiter next state and the memory command to be registered. The pop is
    // decided from the next state so writes drain from the very first
    // blanking cycle.
    always_comb begin
        w_state_next  = r_state;
        w_pop         = 1'b0;
        w_mem_addr_d  = '0;
        w_mem_we_d    = 1'b0;
        w_mem_wdata_d = '0;

        unique case (r_state)
            ST_IDLE:    if (!w_empty) w_state_next = ST_DRAIN;
            ST_DISPLAY: w_state_next = w_empty ? ST_IDLE : ST_DRAIN;
            ST_DRAIN:   if (w_empty) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
        if (at_display_area) begin
            w_state_next = ST_DISPLAY;
        end

        unique case (w_state_next)
            ST_DISPLAY: begin
                w_mem_addr_d = {w_front_bank, r_scan_addr};
            end
            ST_DRAIN: begin
                w_pop         = 1'b1;
                w_mem_we_d    = 1'b1;
                w_mem_addr_d  = {w_back_bank, r_fifo_addr[r_rd_ptr]};
                w_mem_wdata_d = r_fifo_data[r_rd_ptr];
            end
            default: ;
        endcase
    end

    // FIFO storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge vga_clock) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= wr_addr;
            r_fifo_data[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge vga_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_not_full   <= 1'b0;
            r_drop_count <= '0;
            r_scan_addr  <= '0;
            r_frame_ok   <= 1'b0;
            r_valid_sr   <= '0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_not_full  <= (w_count_next != c_full);
            r_mem_addr  <= w_mem_addr_d;
            r_mem_we    <= w_mem_we_d;
            r_mem_wdata <= w_mem_wdata_d;

            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end

            if (vcount >= c_v_active) begin
                r_scan_addr <= '0;
            end else if (at_display_area) begin
                r_scan_addr <= r_scan_addr + ADDR_W'(1);
            end

            // After a reset the scan address is only trustworthy once a
            // vertical blank has been observed.
            if (vcount >= c_v_active) begin
                r_frame_ok <= 1'b1;
            end

            // One stage for the registered address plus RD_LAT memory stages.
            r_valid_sr <= {r_valid_sr[RD_LAT-1:0], at_display_area & r_frame_ok};
        end
    end

`ifdef FB_DOUBLE_BUFFER_EN
    always_ff @(posedge vga_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_front_bank   <= 1'b0;
            r_swap_pending <= 1'b0;
        end else begin
            r_swap_pending <= (r_swap_pending & ~w_do_swap) | swap_req;
            if (w_do_swap) begin
                r_front_bank <= ~r_front_bank;
            end
        end
    end
`endif

    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;
    assign pix_valid  = r_valid_sr[RD_LAT];
    assign pix_data   = pix_valid ? mem_rdata : '0;
    assign fifo_level = r_count;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_fb_arbiter
//  Purpose  : Directed self-checking bench for vga_fb_arbiter. Uses a short
//             frame (640x4 active, 800x6 total) so line geometry and pixel
//             addresses match a 640-wide display. The memory model returns
//             data = address[11:0] two cycles after the address.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_fb_arbiter;

    localparam int c_h_active = 640;
    localparam int c_v_active = 4;
    localparam int c_h_total  = 800;
    localparam int c_v_total  = 6;
    localparam int c_limit    = 10000;

`ifdef FB_DOUBLE_BUFFER_EN
    localparam logic c_back = 1'b1;
`else
    localparam logic c_back = 1'b0;
`endif

    logic        vga_clock;
    logic        reset_n;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        at_display_area;
    logic        wr_valid;
    logic        wr_ready;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;
    logic [19:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [11:0] pix_data;
    logic        pix_valid;
    logic [4:0]  fifo_level;
    logic [15:0] drop_count;
`ifdef FB_DOUBLE_BUFFER_EN
    logic        swap_req;
    logic        swap_done;
`endif

    vga_fb_arbiter #(
        .H_ACTIVE   (c_h_active),
        .V_ACTIVE   (c_v_active),
        .ADDR_W     (19),
        .DATA_W     (12),
        .FIFO_DEPTH (16),
        .RD_LAT     (2)
    ) dut (
        .vga_clock       (vga_clock),
        .reset_n         (reset_n),
        .hcount          (hcount),
        .vcount          (vcount),
        .at_display_area (at_display_area),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .pix_data        (pix_data),
        .pix_valid       (pix_valid),
        .fifo_level      (fifo_level),
`ifdef FB_DOUBLE_BUFFER_EN
        .swap_req        (swap_req),
        .swap_done       (swap_done),
`endif
        .drop_count      (drop_count)
    );

    initial vga_clock = 1'b0;
    always #5 vga_clock = ~vga_clock;

    // Two-cycle read latency memory model.
    logic [11:0] mem_p1;
    always @(posedge vga_clock) begin
        mem_p1    <= mem_addr[11:0];
        mem_rdata <= mem_p1;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int h        = 0;
    int v        = 4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (h=%0d v=%0d)", tag, got, exp, h, v);
        end
    endtask

    function automatic logic [19:0] wr_exp(input int a, input logic bank);
        return {bank, 19'(a)};
    endfunction

    task automatic drive_timing();
        hcount          = 10'(h);
        vcount          = 10'(v);
        at_display_area = (h < c_h_active) && (v < c_v_active);
    endtask

    // Advance one clock; afterwards h/v describe the inputs for the next edge.
    task automatic tick();
        @(posedge vga_clock);
        #1;
        h++;
        if (h == c_h_total) begin
            h = 0;
            v++;
            if (v == c_v_total) v = 0;
        end
        drive_timing();
    endtask

    task automatic run_until(input int hh, input int vv);
        int n = 0;
        while (!(h == hh && v == vv) && n < c_limit) begin
            tick();
            n++;
        end
        if (n >= c_limit) check("run_until_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        logic seen;
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
`ifdef FB_DOUBLE_BUFFER_EN
        swap_req = 1'b0;
`endif
        drive_timing();

        // ---- Reset state, released during vertical blank ----
        tick(); tick(); tick();
        check("rst_wr_ready",   32'(wr_ready),   32'd0);
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        check("rst_pix_valid",  32'(pix_valid),  32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        reset_n = 1'b1;
        tick();
        check("rel_wr_ready",   32'(wr_ready),   32'd1);
        check("rel_fifo_level", 32'(fifo_level), 32'd0);
        check("rel_mem_we",     32'(mem_we),     32'd0);

        seen = 1'b0;
        for (int n = 0; n < c_limit && !(h == 0 && v == 0); n++) begin
            tick();
            seen = seen | pix_valid | mem_we;
        end
        check("blank_no_pv_we", 32'(seen), 32'd0);

        // ---- Scanout alignment: pixel k appears 3 cycles later ----
        tick(); tick();
        check("pv_lat2", 32'(pix_valid), 32'd0);
        tick();
        check("pv_lat3",   32'(pix_valid), 32'd1);
        check("pix_0_0",   32'(pix_data),  32'h000);
        run_until(642, 0);
        check("pv_639_0",  32'(pix_valid), 32'd1);
        check("pix_639_0", 32'(pix_data),  32'h27F);
        tick();
        check("pv_end",    32'(pix_valid), 32'd0);
        check("pix_end",   32'(pix_data),  32'h000);
        run_until(6, 2);
        check("raddr_5_2", 32'(mem_addr),  32'd1285);
        check("rwe_5_2",   32'(mem_we),    32'd0);
        run_until(8, 2);
        check("pv_5_2",    32'(pix_valid), 32'd1);
        check("pix_5_2",   32'(pix_data),  32'h505);

        // ---- 10 writes queued during active, drained in blanking ----
        run_until(100, 3);
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 19'(1000 + i);
            wr_data  = 12'(12'hA00 + i);
            tick();
        end
        wr_valid = 1'b0;
        check("b_level10", 32'(fifo_level), 32'd10);
        seen = 1'b0;
        for (int n = 0; n < c_limit && h != c_h_active; n++) begin
            tick();
            seen = seen | mem_we;
        end
        check("b_no_we_active", 32'(seen), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("b_we",    32'(mem_we),    32'd1);
            check("b_addr",  32'(mem_addr),  32'(wr_exp(1000 + i, c_back)));
            check("b_wdata", 32'(mem_wdata), 32'(12'hA00 + i));
        end
        check("b_level0", 32'(fifo_level), 32'd0);
        tick();
        check("b_idle_we", 32'(mem_we), 32'd0);

        // ---- 20 cycles of wr_valid into a 16-deep queue ----
        run_until(50, 0);
        for (int i = 0; i < 20; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 19'(2000 + i);
            wr_data  = 12'(12'h100 + i);
            tick();
        end
        wr_valid = 1'b0;
        check("c_level16",  32'(fifo_level), 32'd16);
        check("c_ready0",   32'(wr_ready),   32'd0);
        check("c_drop4",    32'(drop_count), 32'd4);
        run_until(641, 0);
        check("c_we",       32'(mem_we),     32'd1);
        check("c_addr0",    32'(mem_addr),   32'(wr_exp(2000, c_back)));
        for (int i = 1; i < 16; i++) begin
            tick();
            check("c_addr",  32'(mem_addr),  32'(wr_exp(2000 + i, c_back)));
            check("c_wdata", 32'(mem_wdata), 32'(12'h100 + i));
        end
        check("c_level0",   32'(fifo_level), 32'd0);

        // ---- Full queue at blanking start with push held ----
        run_until(620, 1);
        for (int j = 0; j < 30; j++) begin
            wr_valid = 1'b1;
            wr_addr  = 19'(3000 + j);
            wr_data  = 12'(j);
            tick();
            if (j == 20) begin
                check("d_level_pp", 32'(fifo_level), 32'd16);
                check("d_ready_pp", 32'(wr_ready),   32'd1);
                check("d_addr0",    32'(mem_addr),   32'(wr_exp(3000, c_back)));
                check("d_we",       32'(mem_we),     32'd1);
            end
            if (j == 29) begin
                check("d_level_hold", 32'(fifo_level), 32'd16);
                check("d_drop8",      32'(drop_count), 32'd8);
            end
        end
        wr_valid = 1'b0;
        tick();
        check("d_level15", 32'(fifo_level), 32'd15);
        tick();
        check("d_level14", 32'(fifo_level), 32'd14);
        run_until(657, 1);
        check("d_addr_j20",  32'(mem_addr),  32'(wr_exp(3020, c_back)));
        check("d_wdata_j20", 32'(mem_wdata), 32'd20);
        run_until(0, 2);
        check("d_level0", 32'(fifo_level), 32'd0);

`ifdef FB_DOUBLE_BUFFER_EN
        // ---- Two swap requests in one frame give a single swap ----
        run_until(100, 2);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        run_until(100, 3);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        run_until(799, 3);
        check("s_done_before", 32'(swap_done), 32'd0);
        tick();
        check("s_done_pulse",  32'(swap_done), 32'd1);
        tick();
        check("s_done_after",  32'(swap_done), 32'd0);
        run_until(1, 0);
        check("s_read_bank1",  32'(mem_addr),  32'h80000);
        run_until(200, 0);
        wr_valid = 1'b1;
        wr_addr  = 19'd77;
        wr_data  = 12'hABC;
        tick();
        wr_valid = 1'b0;
        run_until(641, 0);
        check("s_write_bank0", 32'(mem_addr),  32'(wr_exp(77, 1'b0)));
        check("s_write_we",    32'(mem_we),    32'd1);
        run_until(0, 4);
        check("s_no_reswap",   32'(swap_done), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
